// File: rtl/coeff_replay_fifo.sv
// Replayable coefficient buffer: a host load is closed by a start token,
// then streamed out with one-cycle read latency, with optional looping and rewind.
module coeff_replay_fifo #(
  parameter int                 DATA_W      = 32,
  parameter int                 ADDR_W      = 5,
  parameter logic [DATA_W-1:0]  START_TOKEN = DATA_W'(32'h7F90_0000)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en_i,
  input  logic              redo_i,
  input  logic              clear_i,
  input  logic              loop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              armed_o,
  output logic [ADDR_W:0]   count_o,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              last_o,
  output logic              wr_err_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READY
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   rd_q, rd_d;
  logic              err_d;
  logic              rd_fire;
  logic              wr_fire;
  logic              last_hit;
  logic              is_tok;
  logic              ready;
  logic [DATA_W-1:0] mem [DEPTH];

  assign is_tok   = (data_i == START_TOKEN);
  assign ready    = (state_q == S_READY);
  assign last_hit = (rd_q == len_q - 1'b1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rd_d    = rd_q;
    err_d   = 1'b0;
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    if (clear_i) begin
      state_d = S_IDLE;
      len_d   = '0;
      rd_d    = '0;
    end else begin
      if (ready && redo_i) begin
        rd_d = '0;
      end else if (ready && rd_en_i && (rd_q < len_q)) begin
        rd_fire = 1'b1;
        rd_d    = (last_hit && loop_i) ? '0 : rd_q + 1'b1;
      end
      // Tokens only arm a non-empty, unarmed load; never stored.
      if (wr_en_i) begin
        if (is_tok) begin
          if (state_q == S_LOAD) begin
            state_d = S_READY;
            rd_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end else if (!ready && (len_q != DEPTH_L)) begin
          wr_fire = 1'b1;
          len_d   = len_q + 1'b1;
          state_d = S_LOAD;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      rd_q         <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      last_o       <= 1'b0;
      wr_err_o     <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rd_q         <= rd_d;
      data_valid_o <= rd_fire;
      last_o       <= rd_fire & last_hit;
      wr_err_o     <= err_d;
      if (clear_i) begin
        data_o <= '0;
      end else if (rd_fire) begin
        data_o <= mem[rd_q[ADDR_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem[len_q[ADDR_W-1:0]] <= data_i;
    end
  end

  assign full_o   = (len_q == DEPTH_L);
  assign armed_o  = ready;
  assign empty_o  = !ready || (rd_q == len_q);
  assign count_o  = ready ? (len_q - rd_q) : len_q;
  assign wr_ptr_o = len_q[ADDR_W-1:0];

endmodule
